// File: rtl/adc_gate_pkg.sv
// adc_gate_pkg
// Shared definitions for the ADC capture gate: default widths, the gate
// FSM state encoding and the all-zero beat driven outside a gate window.
package adc_gate_pkg;

  localparam int DATA_W_DEF = 128;  // 8 samples x 16 bit per beat
  localparam int CNT_W_DEF  = 16;   // delay / length / capture counters

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    GATE  = 2'd2
  } gate_state_e;

  localparam logic [DATA_W_DEF-1:0] ZERO_BEAT = '0;

endpackage : adc_gate_pkg

// File: rtl/capture_edge_sync.sv
// capture_edge_sync
// Brings an asynchronous level into the clock domain through two flops and
// emits a one-cycle pulse on its rising edge.
//
// Ports:
//   clk_i    - sampling clock
//   rst_ni   - asynchronous active-low reset
//   async_i  - asynchronous level input
//   pulse_o  - one-cycle pulse on a synchronized 0->1 transition
module capture_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic pulse_o
);

  logic       meta_q;
  logic       sync_q;
  logic       sync_dly_q;
  // Shifts in ones after reset; the edge detector is only armed once
  // sync_dly_q holds a genuine post-reset sample, so a level that is
  // already high when reset releases never looks like a rising edge.
  logic [2:0] armed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_dly_q <= 1'b0;
      armed_q    <= 3'b000;
    end else begin
      meta_q     <= async_i;
      sync_q     <= meta_q;
      sync_dly_q <= sync_q;
      armed_q    <= {armed_q[1:0], 1'b1};
    end
  end

  assign pulse_o = sync_q & ~sync_dly_q & armed_q[2];

endmodule : capture_edge_sync

// File: rtl/adc_capture_gate.sv
// adc_capture_gate
// Opens a timed window on two free-running ADC beat streams. A rising edge
// on capture_i (synchronized internally) starts a sequence: wait delay_i
// cycles, then pass length_i beats of each channel; outside the window the
// outputs carry zero beats. The output streams are valid every cycle.
//
// Ports:
//   aclk, aresetn               - clock, asynchronous active-low reset
//   capture_i                   - asynchronous capture request (rising edge)
//   delay_i, length_i           - window delay / length, latched on the edge
//   adcN_tdata/tvalid/tready    - ADC input streams (tvalid ignored)
//   gateN_tdata/tvalid/tready   - gated output streams (tready ignored)
//   busy_o                      - sequence in progress (DELAY or GATE)
//   capture_count_o             - completed windows, wraps modulo 2^CNT_W
module adc_capture_gate
  import adc_gate_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              capture_i,
  input  logic [CNT_W-1:0]  delay_i,
  input  logic [CNT_W-1:0]  length_i,
  input  logic [DATA_W-1:0] adc0_tdata,
  input  logic              adc0_tvalid,
  output logic              adc0_tready,
  input  logic [DATA_W-1:0] adc1_tdata,
  input  logic              adc1_tvalid,
  output logic              adc1_tready,
  output logic [DATA_W-1:0] gate0_tdata,
  output logic              gate0_tvalid,
  input  logic              gate0_tready,
  output logic [DATA_W-1:0] gate1_tdata,
  output logic              gate1_tvalid,
  input  logic              gate1_tready,
  output logic              busy_o,
  output logic [CNT_W-1:0]  capture_count_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  gate_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] gate0_q, gate1_q;
  logic              run_q;
  logic              edge_pulse;

  // The streams are free-running: upstream valid and downstream ready carry
  // no information for this block.
  logic unused_handshake;
  assign unused_handshake = ^{adc0_tvalid, adc1_tvalid, gate0_tready, gate1_tready};

  capture_edge_sync u_edge (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .async_i (capture_i),
    .pulse_o (edge_pulse)
  );

  // Reset release is taken on a clock edge: stream handshakes rise on the
  // first cycle after aresetn deasserts.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (edge_pulse) begin
          len_d = length_i;
          // A zero-length request is accepted and discarded.
          if (length_i != '0) begin
            if (delay_i == '0) begin
              state_d = GATE;
              cnt_d   = length_i;
            end else begin
              state_d = DELAY;
              cnt_d   = delay_i;
            end
          end
        end
      end
      DELAY: begin
        if (cnt_q == CNT_ONE) begin
          state_d = GATE;
          cnt_d   = len_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GATE: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          count_d = count_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      count_q <= count_d;
    end
  end

  // Output register: a beat is forwarded when it was presented during a
  // GATE cycle, otherwise a zero beat goes out.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      gate0_q <= '0;
      gate1_q <= '0;
    end else if (state_q == GATE) begin
      gate0_q <= adc0_tdata;
      gate1_q <= adc1_tdata;
    end else begin
      gate0_q <= '0;
      gate1_q <= '0;
    end
  end

  assign gate0_tdata     = gate0_q;
  assign gate1_tdata     = gate1_q;
  assign gate0_tvalid    = run_q;
  assign gate1_tvalid    = run_q;
  assign adc0_tready     = run_q;
  assign adc1_tready     = run_q;
  assign busy_o          = (state_q != IDLE);
  assign capture_count_o = count_q;

endmodule : adc_capture_gate

// File: tb/tb_adc_capture_gate.sv
module tb_adc_capture_gate;
  import adc_gate_pkg::*;

  localparam int DW = 128;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          capture_i;
  logic [CW-1:0] delay_i, length_i;
  logic [DW-1:0] adc0_tdata, adc1_tdata;
  logic          adc0_tready, adc1_tready;
  logic [DW-1:0] gate0_tdata, gate1_tdata;
  logic          gate0_tvalid, gate1_tvalid;
  logic          busy_o;
  logic [CW-1:0] capture_count_o;

  // Narrow instance used to exercise counter wrap in few cycles.
  logic          wcap;
  logic [3:0]    wdelay, wlen;
  logic [15:0]   w_g0, w_g1;
  logic          w_v0, w_v1, w_r0, w_r1, w_busy;
  logic [3:0]    w_count;

  logic [15:0]   ramp;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            exp_count = 0;

  always #5 aclk = ~aclk;

  adc_capture_gate #(.DATA_W(DW), .CNT_W(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .capture_i(capture_i),
    .delay_i(delay_i), .length_i(length_i),
    .adc0_tdata(adc0_tdata), .adc0_tvalid(1'b1), .adc0_tready(adc0_tready),
    .adc1_tdata(adc1_tdata), .adc1_tvalid(1'b1), .adc1_tready(adc1_tready),
    .gate0_tdata(gate0_tdata), .gate0_tvalid(gate0_tvalid), .gate0_tready(1'b1),
    .gate1_tdata(gate1_tdata), .gate1_tvalid(gate1_tvalid), .gate1_tready(1'b1),
    .busy_o(busy_o), .capture_count_o(capture_count_o)
  );

  adc_capture_gate #(.DATA_W(16), .CNT_W(4)) dut_w (
    .aclk(aclk), .aresetn(aresetn), .capture_i(wcap),
    .delay_i(wdelay), .length_i(wlen),
    .adc0_tdata(adc0_tdata[15:0]), .adc0_tvalid(1'b1), .adc0_tready(w_r0),
    .adc1_tdata(adc1_tdata[15:0]), .adc1_tvalid(1'b1), .adc1_tready(w_r1),
    .gate0_tdata(w_g0), .gate0_tvalid(w_v0), .gate0_tready(1'b1),
    .gate1_tdata(w_g1), .gate1_tvalid(w_v1), .gate1_tready(1'b1),
    .busy_o(w_busy), .capture_count_o(w_count)
  );

  // Free-running nonzero ADC ramp, updated away from the active edge.
  initial begin
    ramp       = 16'h0101;
    adc0_tdata = {8{ramp}};
    adc1_tdata = ~{8{ramp}};
    forever begin
      @(negedge aclk);
      ramp       = ramp + 16'd1;
      adc0_tdata = {8{ramp}};
      adc1_tdata = ~{8{ramp}};
    end
  end

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  typedef struct {
    int d;       // delay_i
    int l;       // length_i
    int retrig;  // step at which a second capture pulse starts (0 = none)
    int first;   // step of first gated beat (-1 = none)
    int nbeats;  // gated beats expected
    int busy;    // cycles busy_o high
    int inc;     // capture_count_o increment
  } vec_t;

  vec_t vecs[7];

  // Step s = number of clock edges since capture_i was raised.
  // Edge 2 sees the synchronized edge, edge 3 moves the FSM, so the first
  // beat is registered on edge 4 + delay.
  task automatic run_vec(input int idx, input vec_t v);
    int first, last, nb, busy_n, bad_data, bad_strm, budget, gap_ok;
    string tag;
    first = -1; last = -1; nb = 0; busy_n = 0; bad_data = 0; bad_strm = 0;
    budget = v.d + v.l + 12;
    tag = $sformatf("v%0d(d=%0d,l=%0d)", idx, v.d, v.l);
    delay_i   = CW'(v.d);
    length_i  = CW'(v.l);
    capture_i = 1'b1;
    for (int s = 1; s <= budget; s++) begin
      tick();
      if (busy_o) busy_n++;
      if (!gate0_tvalid || !gate1_tvalid || !adc0_tready || !adc1_tready) bad_strm++;
      if (gate0_tdata != '0) begin
        if (first < 0) first = s;
        last = s;
        nb++;
        if (gate0_tdata !== adc0_tdata || gate1_tdata !== adc1_tdata) bad_data++;
      end else if (gate1_tdata != '0) begin
        bad_data++;
      end
      // Input changes after the edge must not disturb the sequence.
      if (s == 3) begin
        capture_i = 1'b0;
        delay_i   = 16'hABCD;
        length_i  = 16'h0000;
      end
      if (v.retrig > 0 && s == v.retrig)     capture_i = 1'b1;
      if (v.retrig > 0 && s == v.retrig + 3) capture_i = 1'b0;
    end
    gap_ok = (nb == 0 || (last - first + 1) == nb) ? 1 : 0;
    exp_count = (exp_count + v.inc) % 65536;
    chk_i({tag, " first_beat_step"}, first, v.first);
    chk_i({tag, " beats"}, nb, v.nbeats);
    chk_i({tag, " contiguous"}, gap_ok, 1);
    chk_i({tag, " data_errors"}, bad_data, 0);
    chk_i({tag, " busy_cycles"}, busy_n, v.busy);
    chk_i({tag, " stream_stalls"}, bad_strm, 0);
    chk_i({tag, " count"}, int'(capture_count_o), exp_count);
    chk_i({tag, " busy_at_end"}, int'(busy_o), 0);
  endtask

  int busy_seen;

  initial begin
    vecs[0] = '{d: 0,  l: 4,  retrig: 0,  first: 4,  nbeats: 4,  busy: 4,  inc: 1};
    vecs[1] = '{d: 64, l: 32, retrig: 0,  first: 68, nbeats: 32, busy: 96, inc: 1};
    vecs[2] = '{d: 0,  l: 0,  retrig: 0,  first: -1, nbeats: 0,  busy: 0,  inc: 0};
    vecs[3] = '{d: 0,  l: 32, retrig: 13, first: 4,  nbeats: 32, busy: 32, inc: 1};
    vecs[4] = '{d: 1,  l: 1,  retrig: 0,  first: 5,  nbeats: 1,  busy: 2,  inc: 1};
    vecs[5] = '{d: 5,  l: 7,  retrig: 0,  first: 9,  nbeats: 7,  busy: 12, inc: 1};
    vecs[6] = '{d: 6,  l: 3,  retrig: 4,  first: 10, nbeats: 3,  busy: 9,  inc: 1};

    aresetn   = 1'b1;
    capture_i = 1'b1;   // held high across reset release
    delay_i   = '0;
    length_i  = 16'd4;
    wcap      = 1'b0;
    wdelay    = 4'd0;
    wlen      = 4'd1;
    #2 aresetn = 1'b0;
    #1;
    chk_v("reset gate0_tdata", gate0_tdata, '0);
    chk_v("reset gate1_tdata", gate1_tdata, '0);
    chk_i("reset gate0_tvalid", int'(gate0_tvalid), 0);
    chk_i("reset adc0_tready", int'(adc0_tready), 0);
    chk_i("reset busy_o", int'(busy_o), 0);
    chk_i("reset count", int'(capture_count_o), 0);
    tick();
    tick();
    chk_i("in-reset gate1_tvalid", int'(gate1_tvalid), 0);
    aresetn = 1'b1;
    tick();
    chk_i("release gate0_tvalid", int'(gate0_tvalid), 1);
    chk_i("release gate1_tvalid", int'(gate1_tvalid), 1);
    chk_i("release adc1_tready", int'(adc1_tready), 1);
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy_o || gate0_tdata != '0) busy_seen++;
    end
    chk_i("held capture no trigger", busy_seen, 0);
    chk_i("held capture count", int'(capture_count_o), 0);
    capture_i = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Asynchronous reset in the middle of a gate window.
    delay_i   = '0;
    length_i  = 16'd16;
    capture_i = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      tick();
      if (s == 3) capture_i = 1'b0;
    end
    chk_i("mid-gate busy before reset", int'(busy_o), 1);
    chk_i("mid-gate beat before reset", int'(gate0_tdata != '0), 1);
    aresetn = 1'b0;
    #1;
    exp_count = 0;
    chk_v("abort gate0_tdata", gate0_tdata, '0);
    chk_v("abort gate1_tdata", gate1_tdata, '0);
    chk_i("abort busy_o", int'(busy_o), 0);
    chk_i("abort count", int'(capture_count_o), 0);
    chk_i("abort gate0_tvalid", int'(gate0_tvalid), 0);
    tick();
    aresetn = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy_o || gate0_tdata != '0) busy_seen++;
    end
    chk_i("post-abort idle", busy_seen, 0);
    chk_i("post-abort count", int'(capture_count_o), 0);
    chk_i("post-abort gate0_tvalid", int'(gate0_tvalid), 1);
    run_vec(7, vecs[0]);

    // Counter wrap on the narrow instance: 16 windows of length 1.
    for (int w = 1; w <= 16; w++) begin
      wcap = 1'b1;
      repeat (3) tick();
      wcap = 1'b0;
      repeat (3) tick();
      if (w == 1)  chk_i("wrap count after 1", int'(w_count), 1);
      if (w == 15) chk_i("wrap count after 15", int'(w_count), 15);
    end
    chk_i("wrap count after 16", int'(w_count), 0);
    chk_i("wrap busy idle", int'(w_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule : tb_adc_capture_gate
